conv_viterbi_codec: RTL and testbench

// - Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) plus hard-decision Viterbi decoder.
// - Encoder drives a noisy channel; the decoder recovers the original bit stream from

---
 rtl/conv_viterbi_codec.sv | 109 ++++++++++
 tb/tb_conv_viterbi_codec.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder and a 4-state hard-decision Viterbi
// decoder with register-exchange survivors; the two halves share only clk/rst.
module conv_viterbi_codec #(
  parameter int TB_LEN = 16,
  parameter int PM_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  typedef logic [PM_W-1:0]   pm_t;
  typedef logic [TB_LEN-1:0] surv_t;

  localparam pm_t PM_INIT = PM_W'(2 ** (PM_W - 2));

  // Hamming distance between the received pair and the pair the encoder emits
  // when it sees bit d while in state p.
  function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic d,
                                               input logic [1:0] rx);
    logic [1:0] diff;
    diff = {d ^ p[1] ^ p[0], d ^ p[0]} ^ rx;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // ---------------- encoder ----------------
  logic [1:0] enc_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state   <= '0;
      enc_d_out   <= '0;
      enc_valid_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      enc_valid_o <= enc_enable_i;
      if (enc_enable_i) begin
        enc_d_out <= {enc_d_in ^ enc_state[1] ^ enc_state[0], enc_d_in ^ enc_state[0]};
        enc_state <= {enc_d_in, enc_state[1]};
      end
    end
  end

  // ---------------- decoder ----------------
  pm_t        pm       [4];
  surv_t      surv     [4];
  pm_t        new_pm   [4];
  surv_t      new_surv [4];
  pm_t        min_pm;
  logic [1:0] best;
  logic [1:0] n_st, p_a, p_b;
  pm_t        cand_a, cand_b;

  // Add-compare-select; predecessors of n are {n[0],0} and {n[0],1}, and the
  // lower-index one wins a tie.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch can be inferred.
    new_pm   = pm;
    new_surv = surv;
    min_pm   = '1;
    best     = 2'd0;
    n_st     = 2'd0;
    p_a      = 2'd0;
    p_b      = 2'd0;
    cand_a   = '0;
    cand_b   = '0;
    for (int n = 0; n < 4; n++) begin
      n_st   = 2'(n);
      p_a    = {n_st[0], 1'b0};
      p_b    = {n_st[0], 1'b1};
      cand_a = pm[p_a] + pm_t'(branch_metric(p_a, n_st[1], dec_d_in));
      cand_b = pm[p_b] + pm_t'(branch_metric(p_b, n_st[1], dec_d_in));
      if (cand_b < cand_a) begin
        new_pm[n_st]   = cand_b;
        new_surv[n_st] = {surv[p_b][TB_LEN-2:0], n_st[1]};
      end else begin
        new_pm[n_st]   = cand_a;
        new_surv[n_st] = {surv[p_a][TB_LEN-2:0], n_st[1]};
      end
      if (new_pm[n_st] < min_pm) begin
        min_pm = new_pm[n_st];
        best   = n_st;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the metric and survivor arrays are tiny and must restart from a
      // known trellis state, so they are reset like ordinary registers.
      pm        <= '{'0, PM_INIT, PM_INIT, PM_INIT};
      surv      <= '{default: '0};
      dec_d_out <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm[2'(i)]   <= new_pm[2'(i)] - min_pm;
        surv[2'(i)] <= new_surv[2'(i)];
      end
      dec_d_out <= new_surv[best][TB_LEN-1];
    end
  end

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Directed bench for conv_viterbi_codec: encoder vectors, loopback, error
// injection, enable gaps and mid-stream reset, all checked by immediate asserts.
module tb_conv_viterbi_codec;

  localparam int TB_LEN = 16;
  localparam int PM_W   = 8;
  localparam int N_SYM  = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       dec_d_out;

  int vectors    = 0;
  int miscompares = 0;
  int run_err    = 0;

  logic       bits    [N_SYM];
  logic [1:0] flips   [N_SYM];
  logic       rec     [N_SYM];
  logic       rec_ref [N_SYM];
  logic [1:0] enc_exp [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic       enc_bits[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  conv_viterbi_codec #(.TB_LEN(TB_LEN), .PM_W(PM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_d_out    (dec_d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enc_valid"}, 32'(enc_valid_o), 32'd0);
    check({tag, "_enc_d_out"}, 32'(enc_d_out), 32'd0);
    check({tag, "_dec_d_out"}, 32'(dec_d_out), 32'd0);
    check({tag, "_pm0"}, 32'(dut.pm[0]), 32'd0);
    check({tag, "_pm1"}, 32'(dut.pm[1]), 32'd64);
    check({tag, "_pm2"}, 32'(dut.pm[2]), 32'd64);
    check({tag, "_pm3"}, 32'(dut.pm[3]), 32'd64);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Decoder output after consuming symbol k, plus normalised-minimum check.
  task automatic dec_check(input int k);
    logic     exp_bit;
    logic [PM_W-1:0] mn;
    exp_bit = (k >= TB_LEN - 1) ? bits[k - (TB_LEN - 1)] : 1'b0;
    rec[k]  = dec_d_out;
    if (dec_d_out !== exp_bit) run_err++;
    mn = dut.pm[0];
    for (int s = 1; s < 4; s++) if (dut.pm[s] < mn) mn = dut.pm[s];
    if (mn !== '0) run_err++;
  endtask

  // Feeds bits[0..n-1] through the encoder, loops enc_d_out (xor flips) into
  // the decoder one symbol behind, optionally with random idle gaps.
  task automatic run_stream(input int n, input bit gaps);
    logic [1:0] m_st, m_exp;
    int         g;
    m_st    = 2'b00;
    m_exp   = 2'b00;
    run_err = 0;
    if (!gaps) begin
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        enc_enable_i = (i < n);
        enc_d_in     = (i < n) ? bits[i] : 1'b0;
        dec_enable   = (i > 0);
        dec_d_in     = (i > 0) ? (enc_d_out ^ flips[i-1]) : 2'b00;
        @(posedge clk);
        #1;
        if (i < n) begin
          m_exp = {bits[i] ^ m_st[1] ^ m_st[0], bits[i] ^ m_st[0]};
          m_st  = {bits[i], m_st[1]};
          if (enc_valid_o !== 1'b1 || enc_d_out !== m_exp) run_err++;
        end
        if (i > 0) dec_check(i - 1);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        enc_enable_i = 1'b1;
        enc_d_in     = bits[i];
        dec_enable   = 1'b0;
        @(posedge clk);
        #1;
        m_exp = {bits[i] ^ m_st[1] ^ m_st[0], bits[i] ^ m_st[0]};
        m_st  = {bits[i], m_st[1]};
        if (enc_valid_o !== 1'b1 || enc_d_out !== m_exp) run_err++;
        g = int'($urandom_range(7, 1));
        repeat (g) begin
          @(negedge clk);
          enc_enable_i = 1'b0;
          enc_d_in     = ~bits[i];
          @(posedge clk);
          #1;
          if (enc_valid_o !== 1'b0 || enc_d_out !== m_exp) run_err++;
        end
        @(negedge clk);
        dec_enable = 1'b1;
        dec_d_in   = enc_d_out ^ flips[i];
        @(posedge clk);
        #1;
        dec_check(i);
        g = int'($urandom_range(7, 1));
        repeat (g) begin
          @(negedge clk);
          dec_enable = 1'b0;
          dec_d_in   = ~dec_d_in;
          @(posedge clk);
          #1;
          if (dec_d_out !== rec[i]) run_err++;
        end
      end
    end
    @(negedge clk);
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;
  endtask

  initial begin
    int gap_diff;

    // Reset state
    #12;
    check_reset_state("reset");
    rst = 1'b1;

    // Encoder directed vector, each consumption followed by one idle clock
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enc_enable_i = 1'b1;
      enc_d_in     = enc_bits[i];
      @(posedge clk);
      #1;
      check($sformatf("enc_out_%0d", i), 32'(enc_d_out), 32'(enc_exp[i]));
      check($sformatf("enc_valid_%0d", i), 32'(enc_valid_o), 32'd1);
      @(negedge clk);
      enc_enable_i = 1'b0;
      enc_d_in     = ~enc_bits[i];
      @(posedge clk);
      #1;
      check($sformatf("enc_hold_%0d", i), 32'(enc_d_out), 32'(enc_exp[i]));
      check($sformatf("enc_idle_valid_%0d", i), 32'(enc_valid_o), 32'd0);
    end

    // Error-free loopback of random bits
    for (int i = 0; i < N_SYM; i++) begin
      bits[i]  = 1'($urandom);
      flips[i] = 2'b00;
    end
    pulse_reset();
    run_stream(N_SYM, 1'b0);
    check("loopback_errors", 32'(run_err), 32'd0);
    for (int i = 0; i < N_SYM; i++) rec_ref[i] = rec[i];

    // Same stream with random idle gaps on both halves
    pulse_reset();
    run_stream(N_SYM, 1'b1);
    check("gap_errors", 32'(run_err), 32'd0);
    gap_diff = 0;
    for (int i = 0; i < N_SYM; i++) if (rec[i] !== rec_ref[i]) gap_diff++;
    check("gap_vs_gapless", 32'(gap_diff), 32'd0);

    // Bit[0] flipped on two consecutive symbols every 16 symbols
    for (int i = 0; i < N_SYM; i++) begin
      bits[i]  = 1'($urandom);
      flips[i] = ((i % 16 == 2) || (i % 16 == 3)) ? 2'b01 : 2'b00;
    end
    pulse_reset();
    run_stream(N_SYM, 1'b0);
    check("inject_errors", 32'(run_err), 32'd0);

    // All-zero stream with one flipped bit on symbol 5
    for (int i = 0; i < N_SYM; i++) begin
      bits[i]  = 1'b0;
      flips[i] = 2'b00;
    end
    flips[5] = 2'b10;
    pulse_reset();
    run_stream(40, 1'b0);
    check("zero_single_error", 32'(run_err), 32'd0);

    // All-ones stream, then asynchronous reset between clock edges
    for (int i = 0; i < N_SYM; i++) begin
      bits[i]  = 1'b1;
      flips[i] = 2'b00;
    end
    pulse_reset();
    run_stream(20, 1'b0);
    check("ones_errors", 32'(run_err), 32'd0);
    check("pre_reset_enc_d_out", 32'(enc_d_out), 32'h2);
    check("pre_reset_dec_d_out", 32'(dec_d_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst = 1'b1;

    // First stream after the reset restarts at symbol 0
    for (int i = 0; i < N_SYM; i++) bits[i] = 1'($urandom);
    run_stream(48, 1'b0);
    check("post_reset_errors", 32'(run_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
